// File: rtl/clock_display_scanner.sv
// Six-digit multiplexed 7-segment scanner for the clock (HH MM SS).
// Frame-coherent input snapshot, BCD decode, guard blanking and blink.
module clock_display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [4:0] current_hours,
  input  logic [5:0] current_minutes,
  input  logic [5:0] current_seconds,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic [2:0] display_mode,
  input  logic       alarm_active,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GUARD_V    = SW'(GUARD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {
    MODE_TIME   = 3'd0,
    MODE_SET_H  = 3'd1,
    MODE_SET_M  = 3'd2,
    MODE_SET_AH = 3'd3,
    MODE_SET_AM = 3'd4
  } mode_t;

  function automatic mode_t norm_mode(input logic [2:0] m);
    return (m > 3'd4) ? MODE_TIME : mode_t'(m);
  endfunction

  // Repeated subtraction keeps the divide-by-ten small and width-exact.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  function automatic logic [6:0] to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          prime;

  logic [4:0] snap_hours;
  logic [5:0] snap_minutes;
  logic [5:0] snap_seconds;
  logic [4:0] snap_alarm_hours;
  logic [5:0] snap_alarm_minutes;
  logic [2:0] snap_mode;

  logic slot_last;
  logic frame_wrap;
  logic frame_start;

  assign slot_last   = (scan_cnt == SCAN_LAST);
  assign frame_wrap  = slot_last && (idx == 3'd5);
  assign frame_start = prime || frame_wrap;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= 3'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      scan_cnt <= slot_last ? '0 : scan_cnt + SW'(1);
      if (slot_last) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      if (frame_wrap) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // alarm_active is not latched: blanking and dp follow it live.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      prime              <= 1'b1;
      snap_hours         <= '0;
      snap_minutes       <= '0;
      snap_seconds       <= '0;
      snap_alarm_hours   <= '0;
      snap_alarm_minutes <= '0;
      snap_mode          <= '0;
    end else if (frame_start) begin
      prime              <= 1'b0;
      snap_hours         <= current_hours;
      snap_minutes       <= current_minutes;
      snap_seconds       <= current_seconds;
      snap_alarm_hours   <= alarm_hours;
      snap_alarm_minutes <= alarm_minutes;
      snap_mode          <= display_mode;
    end
  end

  mode_t      src_mode;
  mode_t      live_mode;
  logic       show_alarm;
  logic [4:0] hours_v;
  logic [5:0] minutes_v;
  logic [7:0] hours_bcd;
  logic [7:0] minutes_bcd;
  logic [7:0] seconds_bcd;
  logic       hours_ok;
  logic       minutes_ok;
  logic       seconds_ok;

  always_comb begin
    src_mode    = norm_mode(snap_mode);
    live_mode   = norm_mode(display_mode);
    show_alarm  = (src_mode == MODE_SET_AH) ||
                  (src_mode == MODE_SET_AM);
    hours_v     = show_alarm ? snap_alarm_hours : snap_hours;
    minutes_v   = show_alarm ? snap_alarm_minutes : snap_minutes;
    hours_bcd   = to_bcd({1'b0, hours_v});
    minutes_bcd = to_bcd(minutes_v);
    seconds_bcd = to_bcd(snap_seconds);
    hours_ok    = (hours_v <= 5'd23);
    minutes_ok  = (minutes_v <= 6'd59);
    seconds_ok  = (snap_seconds <= 6'd59);
  end

  logic [6:0] digit;

  always_comb begin
    digit = SEG_BLANK;
    unique case (idx)
      3'd0: digit = show_alarm ? SEG_BLANK :
                    seconds_ok ? to_seg(seconds_bcd[3:0]) : SEG_DASH;
      3'd1: digit = show_alarm ? SEG_BLANK :
                    seconds_ok ? to_seg(seconds_bcd[7:4]) : SEG_DASH;
      3'd2: digit = minutes_ok ? to_seg(minutes_bcd[3:0]) : SEG_DASH;
      3'd3: digit = minutes_ok ? to_seg(minutes_bcd[7:4]) : SEG_DASH;
      3'd4: digit = hours_ok ? to_seg(hours_bcd[3:0]) : SEG_DASH;
      3'd5: digit = hours_ok ? to_seg(hours_bcd[7:4]) : SEG_DASH;
      default: digit = SEG_BLANK;
    endcase
  end

  logic       blank;
  logic [5:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // Set-mode blink wins; the ringing alarm only blinks in plain time view.
  always_comb begin
    blank = 1'b0;
    if (blink_phase) begin
      unique case (live_mode)
        MODE_SET_H, MODE_SET_AH: blank = (idx >= 3'd4);
        MODE_SET_M, MODE_SET_AM: blank = (idx == 3'd2) || (idx == 3'd3);
        default:                 blank = alarm_active;
      endcase
    end
  end

  always_comb begin
    an_next  = (scan_cnt < GUARD_V) ? 6'h3F : ~(6'b000001 << idx);
    seg_next = blank ? SEG_BLANK : digit;
    dp_next  = 1'b1;
    if (alarm_active) begin
      dp_next = 1'b0;
    end else if (!blink_phase && ((idx == 3'd2) || (idx == 3'd4))) begin
      dp_next = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      an  <= 6'h3F;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_clock_display_scanner.sv
// Scoreboard bench for clock_display_scanner: per-cycle an/seg/dp
// predictions derived from time since reset and frame-start captures.
module tb_clock_display_scanner;

  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 6 * SD;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [4:0] current_hours;
  logic [5:0] current_minutes;
  logic [5:0] current_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [2:0] display_mode;
  logic       alarm_active;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  clock_display_scanner #(
    .SCAN_DIV(SD),
    .GUARD(GD),
    .BLINK_FRAMES(BF)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .current_hours(current_hours),
    .current_minutes(current_minutes),
    .current_seconds(current_seconds),
    .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes),
    .display_mode(display_mode),
    .alarm_active(alarm_active),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    int         e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int e;
  int m_h, m_m, m_s, m_ah, m_am, m_mode;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] fld(input int v, input int maxv,
                                     input bit tens);
    if (v > maxv) return 7'b0111111;
    return enc(tens ? v / 10 : v % 10);
  endfunction

  function automatic exp_t predict();
    exp_t x;
    int cnt, slot, blink, sm, lm, hv, mv;
    bit src, blank, alm;
    cnt   = e % SD;
    slot  = (e / SD) % 6;
    blink = ((e / FRAME) / BF) % 2;
    sm    = (m_mode > 4) ? 0 : m_mode;
    lm    = int'(display_mode);
    if (lm > 4) lm = 0;
    alm   = (alarm_active === 1'b1);
    src   = (sm >= 3);
    hv    = src ? m_ah : m_h;
    mv    = src ? m_am : m_m;
    case (slot)
      0: x.seg = src ? 7'h7F : fld(m_s, 59, 1'b0);
      1: x.seg = src ? 7'h7F : fld(m_s, 59, 1'b1);
      2: x.seg = fld(mv, 59, 1'b0);
      3: x.seg = fld(mv, 59, 1'b1);
      4: x.seg = fld(hv, 23, 1'b0);
      default: x.seg = fld(hv, 23, 1'b1);
    endcase
    blank = (blink == 1) &&
            ((((lm == 1) || (lm == 3)) && (slot >= 4)) ||
             (((lm == 2) || (lm == 4)) && ((slot == 2) || (slot == 3))) ||
             ((lm == 0) && alm));
    if (blank) x.seg = 7'h7F;
    if (alm) x.dp = 1'b0;
    else x.dp = ((blink == 0) && ((slot == 2) || (slot == 4))) ? 1'b0 : 1'b1;
    x.an = (cnt < GD) ? 6'h3F : (6'h3F ^ 6'(1 << slot));
    x.e  = e;
    return x;
  endfunction

  task automatic step();
    exp_t x;
    @(posedge sys_clk);
    sb.push_back(predict());
    if ((e == 0) || (e % FRAME == FRAME - 1)) begin
      m_h    = int'(current_hours);
      m_m    = int'(current_minutes);
      m_s    = int'(current_seconds);
      m_ah   = int'(alarm_hours);
      m_am   = int'(alarm_minutes);
      m_mode = int'(display_mode);
    end
    e++;
    @(negedge sys_clk);
    if (sb.size() == 0) begin
      check("sb_empty", 8'd0, 8'd1);
    end else begin
      x = sb.pop_front();
      check($sformatf("an@%0d", x.e), 8'(an), 8'(x.an));
      check($sformatf("seg@%0d", x.e), 8'(seg), 8'(x.seg));
      check($sformatf("dp@%0d", x.e), 8'(dp), 8'(x.dp));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic restart();
    e      = 0;
    m_h    = 0;
    m_m    = 0;
    m_s    = 0;
    m_ah   = 0;
    m_am   = 0;
    m_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    current_hours   = 5'd12;
    current_minutes = 6'd34;
    current_seconds = 6'd56;
    alarm_hours     = 5'd7;
    alarm_minutes   = 6'd30;
    display_mode    = 3'd0;
    alarm_active    = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_an", 8'(an), 8'h3F);
    check("rst_seg", 8'(seg), 8'h7F);
    check("rst_dp", 8'(dp), 8'h01);
    rst = 1'b0;
    restart();

    run(FRAME + 20);
    current_seconds = 6'd57;
    run(2 * FRAME - (FRAME + 20) + FRAME);

    display_mode = 3'd1;
    run(4 * FRAME);

    display_mode = 3'd4;
    run(4 * FRAME);

    display_mode    = 3'd0;
    current_hours   = 5'd25;
    current_minutes = 6'd60;
    run(2 * FRAME);

    alarm_active = 1'b1;
    run(4 * FRAME);

    @(posedge sys_clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_an", 8'(an), 8'h3F);
    check("mid_rst_seg", 8'(seg), 8'h7F);
    check("mid_rst_dp", 8'(dp), 8'h01);
    @(negedge sys_clk);
    rst             = 1'b0;
    current_hours   = 5'd12;
    current_minutes = 6'd34;
    alarm_active    = 1'b0;
    restart();
    run(2 * FRAME);

    check("sb_drain", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
